// File: rtl/ascon_bd_block_bridge.sv
// ascon_bd_block_bridge
// Host-side bridge between a wide block stream and the 16-bit toggle-handshake
// port of ascon_engine. A block of up to BLOCK_W bits is sent as 16-bit beats,
// MSB-first. The engine's responses can optionally be collected into a wide,
// left-aligned result.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s_valid/s_ready              block input handshake
//   s_data, s_beats              block payload (MSB-first) and beat count
//   s_cmd, s_mode, s_collect     command code, mode bits, collect-response flag
//   m_valid/m_ready              result handshake
//   m_data, m_beats              collected beats (left-aligned) and their count
//   bd_in_data/bd_in_config      beat and config to the engine
//   bd_out_data/bd_out_config    response and ack toggle (bit 2) from the engine
//   busy                         block in progress (not idle)
//   err, err_clr                 sticky handshake-watchdog error and its clear
module ascon_bd_block_bridge #(
  parameter int unsigned BLOCK_W        = 128,
  parameter int unsigned CNT_W          = $clog2(BLOCK_W / 16 + 1),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BLOCK_W-1:0] s_data,
  input  logic [CNT_W-1:0]   s_beats,
  input  logic [3:0]         s_cmd,
  input  logic [3:0]         s_mode,
  input  logic               s_collect,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BLOCK_W-1:0] m_data,
  output logic [CNT_W-1:0]   m_beats,
  output logic [15:0]        bd_in_data,
  output logic [15:0]        bd_in_config,
  input  logic [15:0]        bd_out_data,
  input  logic [15:0]        bd_out_config,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);

  localparam int unsigned N       = BLOCK_W / 16;
  localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t             state;
  logic               tx_toggle;
  logic               rx_prev;
  logic               collect;
  logic [BLOCK_W-1:0] shift_reg;
  logic [BLOCK_W-1:0] resp;
  logic [CNT_W-1:0]   beat_idx;
  logic [CNT_W-1:0]   beat_cnt;
  logic [WD_W-1:0]    wd_cnt;

  logic               ack_c;
  logic [CNT_W-1:0]   beats_clamped_c;
  logic [BLOCK_W-1:0] resp_next_c;
  logic [BLOCK_W-1:0] resp_aligned_c;
  int unsigned        align_shift_c;

  // Only the ack toggle bit of the engine config is meaningful here
  logic unused_cfg;
  assign unused_cfg = ^{bd_out_config[15:3], bd_out_config[1:0]};

  // Ack detect, count clamp and response shift/alignment
  always_comb begin
    ack_c           = (bd_out_config[2] != rx_prev);
    beats_clamped_c = ((s_beats == '0) || (s_beats > N_CNT)) ? N_CNT : s_beats;
    resp_next_c     = (resp << 16) | BLOCK_W'(bd_out_data);
    align_shift_c   = 16 * (N - 32'(beat_cnt));
    resp_aligned_c  = resp_next_c << align_shift_c;
  end

  // Beat sequencer, response collector and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tx_toggle    <= 1'b0;
      rx_prev      <= 1'b0;
      collect      <= 1'b0;
      shift_reg    <= '0;
      resp         <= '0;
      beat_idx     <= '0;
      beat_cnt     <= '0;
      wd_cnt       <= '0;
      s_ready      <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_beats      <= '0;
      bd_in_data   <= '0;
      bd_in_config <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            beat_cnt     <= beats_clamped_c;
            collect      <= s_collect;
            tx_toggle    <= ~tx_toggle;
            bd_in_data   <= s_data[BLOCK_W-1 -: 16];
            shift_reg    <= s_data << 16;
            bd_in_config <= {5'd0, s_cmd, (beats_clamped_c == CNT_W'(1)), 1'b0, s_mode, ~tx_toggle};
            beat_idx     <= CNT_W'(1);
            resp         <= '0;
            wd_cnt       <= '0;
            s_ready      <= 1'b0;
            busy         <= 1'b1;
            state        <= WAIT;
          end else begin
            s_ready <= 1'b1;
          end
        end

        WAIT: begin
          // An ack in the expiry cycle takes priority over the watchdog
          if (ack_c) begin
            rx_prev <= ~rx_prev;
            wd_cnt  <= '0;
            if (collect) begin
              resp <= resp_next_c;
            end
            if (!bd_in_config[6]) begin
              tx_toggle       <= ~tx_toggle;
              bd_in_data      <= shift_reg[BLOCK_W-1 -: 16];
              shift_reg       <= shift_reg << 16;
              bd_in_config[6] <= (beat_idx == beat_cnt - CNT_W'(1));
              bd_in_config[0] <= ~tx_toggle;
              beat_idx        <= beat_idx + CNT_W'(1);
            end else if (collect) begin
              m_valid <= 1'b1;
              m_data  <= resp_aligned_c;
              m_beats <= beat_cnt;
              state   <= RESP;
            end else begin
              s_ready <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (wd_cnt == WD_LAST) begin
              err   <= 1'b1;
              state <= ERR;
            end else begin
              wd_cnt <= wd_cnt + WD_W'(1);
            end
          end
        end

        RESP: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        ERR: begin
          // Toggles are kept so the engine handshake stays aligned
          if (err_clr) begin
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_bd_block_bridge.sv
// Directed bench for ascon_bd_block_bridge with a toggle-echo engine model.
module tb_ascon_bd_block_bridge;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned CNT_W   = 4;
  localparam int          LIMIT   = 400;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [BLOCK_W-1:0] s_data;
  logic [CNT_W-1:0]   s_beats;
  logic [3:0]         s_cmd;
  logic [3:0]         s_mode;
  logic               s_collect;
  logic               m_valid;
  logic               m_ready;
  logic [BLOCK_W-1:0] m_data;
  logic [CNT_W-1:0]   m_beats;
  logic [15:0]        bd_in_data;
  logic [15:0]        bd_in_config;
  logic [15:0]        bd_out_data;
  logic [15:0]        bd_out_config;
  logic               busy;
  logic               err;
  logic               err_clr;

  int errors = 0;
  int checks = 0;

  // Engine model state (written only by the responder)
  logic eng_seen;
  logic next_first;
  int   pend;
  int   ack_i;
  // Engine model controls (written only by the main sequence)
  logic resp_en;
  int   resp_lat;
  // Beat monitor (written only by the monitor)
  logic        mon_prev;
  logic [15:0] mq_data[$];
  logic [15:0] mq_cfg[$];

  ascon_bd_block_bridge #(
    .BLOCK_W(BLOCK_W),
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_beats(s_beats),
    .s_cmd(s_cmd),
    .s_mode(s_mode),
    .s_collect(s_collect),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_beats(m_beats),
    .bd_in_data(bd_in_data),
    .bd_in_config(bd_in_config),
    .bd_out_data(bd_out_data),
    .bd_out_config(bd_out_config),
    .busy(busy),
    .err(err),
    .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  // Engine model: echoes the beat toggle resp_lat cycles later, data A000+i
  initial begin
    eng_seen      = 1'b0;
    next_first    = 1'b1;
    pend          = 0;
    ack_i         = 0;
    bd_out_data   = 16'h0000;
    bd_out_config = 16'h0000;
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        eng_seen      = 1'b0;
        next_first    = 1'b1;
        pend          = 0;
        bd_out_data   = 16'h0000;
        bd_out_config = 16'h0000;
      end else if (resp_en) begin
        if (pend == 0 && bd_in_config[0] != eng_seen) begin
          eng_seen = bd_in_config[0];
          if (next_first) ack_i = 0;
          next_first = bd_in_config[6];
          pend = resp_lat;
        end
        if (pend > 0) begin
          pend = pend - 1;
          if (pend == 0) begin
            bd_out_data      = 16'hA000 + 16'(ack_i);
            ack_i            = ack_i + 1;
            bd_out_config[2] = eng_seen;
          end
        end
      end
    end
  end

  // Records every beat the bridge drives (one per tx toggle flip)
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev = 1'b0;
      end else if (bd_in_config[0] != mon_prev) begin
        mon_prev = bd_in_config[0];
        mq_data.push_back(bd_in_data);
        mq_cfg.push_back(bd_in_config);
      end
    end
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input logic [127:0] d, input logic [3:0] b, input logic [3:0] cmd,
                             input logic [3:0] mode, input logic col, input string tag);
    int n;
    @(negedge clk);
    s_data    = d;
    s_beats   = b;
    s_cmd     = cmd;
    s_mode    = mode;
    s_collect = col;
    s_valid   = 1'b1;
    n = 0;
    while (!s_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_wait"}, 160'(n < LIMIT), 160'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_m_valid(input string tag);
    int n;
    n = 0;
    while (!m_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_m_valid_wait"}, 160'(n < LIMIT), 160'(1));
  endtask

  task automatic wait_s_ready(input string tag);
    int n;
    n = 0;
    while (!s_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_s_ready_wait"}, 160'(n < LIMIT), 160'(1));
  endtask

  logic [127:0] key;
  logic [127:0] exp8;
  int           base;
  int           n;
  logic [15:0]  held_data;
  logic [15:0]  held_cfg;
  logic         tog0;

  initial begin
    key  = 128'h000102030405060708090A0B0C0D0E0F;
    exp8 = 128'hA000A001A002A003A004A005A006A007;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_beats   = '0;
    s_cmd     = '0;
    s_mode    = '0;
    s_collect = 1'b0;
    m_ready   = 1'b1;
    err_clr   = 1'b0;
    resp_en   = 1'b1;
    resp_lat  = 3;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 160'(s_ready), 160'(0));
    check("rst_outputs", {m_valid, m_beats, busy, err, bd_in_data, bd_in_config},
          {1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0});
    check("rst_m_data", 160'(m_data), 160'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", 160'(s_ready), 160'(1));

    // Key block: 8 beats, no collect, cmd 5, mode A
    base = mq_data.size();
    start_block(key, 4'd8, 4'h5, 4'hA, 1'b0, "key");
    check("key_busy", 160'(busy), 160'(1));
    check("key_beat0_live", {bd_in_data, bd_in_config}, {16'h0001, 16'h0295});
    n = 0;
    while (ack_i < 8 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("key_ack_wait", 160'(n < LIMIT), 160'(1));
    check("key_s_ready_before_last_ack", 160'(s_ready), 160'(0));
    @(posedge clk);
    #1;
    check("key_s_ready_after_last_ack", {s_ready, busy}, {1'b1, 1'b0});
    check("key_beat_count", 160'(mq_data.size() - base), 160'(8));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("key_data%0d", i), 160'(mq_data[base+i]), 160'({8'(2*i), 8'(2*i+1)}));
      check($sformatf("key_cfg%0d", i), 160'(mq_cfg[base+i]),
            160'(16'h0294 | ((i == 7) ? 16'h0040 : 16'h0000) | ((i % 2 == 0) ? 16'h0001 : 16'h0000)));
    end

    // Collect 8 beats
    start_block(key, 4'd8, 4'h3, 4'h1, 1'b1, "col8");
    wait_m_valid("col8");
    check("col8_m_data", 160'(m_data), 160'(exp8));
    check("col8_m_beats_s_ready", {m_beats, s_ready}, {4'd8, 1'b0});
    @(posedge clk);
    #1;
    check("col8_done", {m_valid, s_ready, busy}, {1'b0, 1'b1, 1'b0});

    // Partial block: 2 beats, collect
    base = mq_data.size();
    start_block(128'h11112222333344445555666677778888, 4'd2, 4'h7, 4'h0, 1'b1, "part");
    wait_m_valid("part");
    check("part_m_data", 160'(m_data), 160'({32'hA000A001, 96'h0}));
    check("part_m_beats", 160'(m_beats), 160'(2));
    @(posedge clk);
    repeat (6) @(negedge clk);
    check("part_beat_count", 160'(mq_data.size() - base), 160'(2));
    check("part_beats_data", {mq_data[base], mq_data[base+1]}, {16'h1111, 16'h2222});
    check("part_last_bits", {mq_cfg[base][6], mq_cfg[base+1][6]}, {1'b0, 1'b1});

    // Backpressure, with an out-of-range count clamped to 8 beats
    m_ready = 1'b0;
    start_block(key, 4'd9, 4'h1, 4'h2, 1'b1, "bp");
    wait_m_valid("bp");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i), {m_valid, s_ready, m_beats, m_data},
            {1'b1, 1'b0, 4'd8, exp8});
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {m_valid, s_ready, busy}, {1'b0, 1'b1, 1'b0});

    // Ack arriving in the watchdog expiry cycle wins
    resp_lat = 16;
    start_block(key, 4'd2, 4'h2, 4'h3, 1'b0, "race");
    tog0 = bd_in_config[0];
    repeat (16) @(posedge clk);
    #1;
    check("race_ack_wins", {err, busy, bd_in_config[6], bd_in_config[0], bd_in_data},
          {1'b0, 1'b1, 1'b1, ~tog0, 16'h0203});
    wait_s_ready("race");
    check("race_no_err", 160'(err), 160'(0));

    // Silent engine: watchdog fires exactly 16 WAIT cycles after beat 0
    resp_en  = 1'b0;
    resp_lat = 3;
    start_block(128'hBEEF0000000000000000000000000000, 4'd4, 4'h9, 4'h4, 1'b0, "wd");
    held_data = bd_in_data;
    held_cfg  = bd_in_config;
    repeat (15) @(posedge clk);
    #1;
    check("wd_before_expiry", {err, busy}, {1'b0, 1'b1});
    @(posedge clk);
    #1;
    check("wd_expiry", {err, s_ready}, {1'b1, 1'b0});
    repeat (5) @(posedge clk);
    #1;
    check("wd_err_hold", {err, s_ready, busy, bd_in_data, bd_in_config},
          {1'b1, 1'b0, 1'b1, 16'hBEEF, held_cfg});
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("wd_cleared", {err, s_ready, busy}, {1'b0, 1'b1, 1'b0});

    // Realign engine and bridge, then reset in the middle of a block
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    resp_en = 1'b1;
    wait_s_ready("rst_mid_pre");
    base = mq_data.size();
    start_block(key, 4'd8, 4'h6, 4'h6, 1'b0, "rst_mid");
    n = 0;
    while ((mq_data.size() - base) < 4 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_beat4_wait", 160'(n < LIMIT), 160'(1));
    check("rst_mid_beat4_data", 160'(bd_in_data), 160'(16'h0607));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outputs", {s_ready, m_valid, m_beats, busy, err, bd_in_data, bd_in_config},
          {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0});
    check("rst_mid_m_data", 160'(m_data), 160'(0));
    @(negedge clk);
    rst = 1'b0;
    wait_s_ready("rst_mid_post");
    start_block(key, 4'd8, 4'h6, 4'h6, 1'b1, "after_rst");
    check("after_rst_toggle", {bd_in_config[0], bd_in_data}, {1'b1, 16'h0001});
    wait_m_valid("after_rst");
    check("after_rst_m_data", {m_beats, m_data}, {4'd8, exp8});
    @(posedge clk);
    #1;
    check("after_rst_done", {m_valid, s_ready, err}, {1'b0, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
